gate_truth_checker: RTL and testbench

Sequential stimulus-and-check stage for the two-input gate library. It sits directly upstream of a gate under test such as `norgate`, driving that gate's `a`/`b` inputs through all four input combinations. It consumes the gate's `c` output and compares each sample against the expected truth table for a selected gate function. It reports pass/fail, a per-vector failure mask and a mismatch count, so self-checking replaces manual `$monitor` inspection.

---
 rtl/gate_pkg.sv | 37 +++
 rtl/gate_truth_checker.sv | 137 +++++++++++++
 tb/tb_gate_truth_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate library checkers: function codes,
// checker FSM encoding and the single reference truth table.
package gate_pkg;

    typedef enum logic [2:0] {
        GF_AND   = 3'd0,
        GF_OR    = 3'd1,
        GF_NAND  = 3'd2,
        GF_NOR   = 3'd3,
        GF_XOR   = 3'd4,
        GF_XNOR  = 3'd5,
        GF_BUF_A = 3'd6,
        GF_NOT_A = 3'd7
    } gate_func_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    function automatic logic gate_expected(gate_func_e f, logic a, logic b);
        logic r;
        case (f)
            GF_AND:   r = a & b;
            GF_OR:    r = a | b;
            GF_NAND:  r = ~(a & b);
            GF_NOR:   r = ~(a | b);
            GF_XOR:   r = a ^ b;
            GF_XNOR:  r = ~(a ^ b);
            GF_BUF_A: r = a;
            default:  r = ~a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_truth_checker.sv
// Drives a/b through 00,01,10,11 (SETTLE cycles each), checks c against the selected truth table.
// Latency: done pulses 4*SETTLE+1 cycles after start is accepted.
// Backpressure: none; start is only accepted in IDLE and is dropped otherwise.
module gate_truth_checker
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] func,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    chk_state_e state_q, state_d;
    gate_func_e func_q, func_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       mismatch;
    logic [1:0] idx_next;

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        mismatch = 1'b0;
        idx_next = idx_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_DRIVE;
                    func_d  = gate_func_e'(func);
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    // c has settled for the whole hold window; a_q/b_q still equal idx_q here
                    mismatch = (c != gate_expected(func_q, idx_q[1], idx_q[0]));
                    if (mismatch) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    cnt_d = 4'd0;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        idx_d = idx_next;
                        a_d   = idx_next[1];
                        b_d   = idx_next[0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            func_q  <= GF_AND;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: two checkers (SETTLE=2 and 3) fed by table-driven fake gates.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v;
    logic [2:0] func_v [2];
    logic [3:0] tt_v   [2];
    logic [1:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [2:0] err_v  [2];
    logic [3:0] fail_v [2];

    typedef struct {
        logic [3:0] fail;
        logic [2:0] errs;
        logic       pass;
        int         lat;
        int         start_cyc;
    } exp_t;

    exp_t exp_q [2][$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : 3;
    endfunction

    function automatic bit ref_bit(input int f, input int a, input int b);
        case (f)
            0: return (a + b) == 2;
            1: return (a + b) >= 1;
            2: return (a + b) != 2;
            3: return (a + b) == 0;
            4: return (a + b) == 1;
            5: return (a + b) != 1;
            6: return a == 1;
            default: return a == 0;
        endcase
    endfunction

    // gate table tt: bit i is the gate output for {a,b}=i
    function automatic exp_t model(input int f, input logic [3:0] tt, input int s);
        exp_t e;
        e.fail = 4'd0;
        e.errs = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (tt[i] != ref_bit(f, i / 2, i % 2)) begin
                e.fail[i] = 1'b1;
                e.errs    = e.errs + 3'd1;
            end
        end
        e.pass      = (e.errs == 3'd0);
        e.lat       = 4 * s + 1;
        e.start_cyc = 0;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned S = (g == 0) ? 2 : 3;
        logic       c;
        logic [1:0] trace [$];
        logic       prev_done;

        assign c = tt_v[g][{a_v[g], b_v[g]}];

        gate_truth_checker #(.SETTLE(S)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .func      (func_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .c         (c),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .pass      (pass_v[g]),
            .err_count (err_v[g]),
            .fail_vec  (fail_v[g])
        );

        always @(negedge clk) begin : mon
            exp_t e;
            int   bad;
            if (rst) begin
                trace.delete();
                prev_done = 1'b0;
            end else begin
                if (busy_v[g]) trace.push_back({a_v[g], b_v[g]});
                if (done_v[g]) begin
                    chk("done_single_cycle", 32'(prev_done), 0);
                    chk("done_expected", 32'(exp_q[g].size() != 0), 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        chk("fail_vec", 32'(fail_v[g]), 32'(e.fail));
                        chk("err_count", 32'(err_v[g]), 32'(e.errs));
                        chk("pass", 32'(pass_v[g]), 32'(e.pass));
                        chk("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                        chk("busy_at_done", 32'(busy_v[g]), 0);
                        chk("ab_idle_at_done", 32'({a_v[g], b_v[g]}), 0);
                        bad = (trace.size() != 4 * S) ? 1 : 0;
                        if (bad == 0) begin
                            for (int k = 0; k < 4 * S; k++)
                                if (trace[k] != 2'(k / S)) bad = 1;
                        end
                        chk("vector_trace", 32'(bad), 0);
                    end
                    trace.delete();
                end
                prev_done = done_v[g];
            end
        end
    end

    task automatic start_run(input int g, input int f, input logic [3:0] tt, input bit expect_done);
        exp_t e;
        @(negedge clk);
        tt_v[g]    = tt;
        func_v[g]  = 3'(f);
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        e = model(f, tt, settle_of(g));
        e.start_cyc = cyc;
        if (expect_done) exp_q[g].push_back(e);
    endtask

    task automatic drain(input int g);
        int n = 0;
        while (exp_q[g].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q[g].size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start_v   = 2'b00;
        func_v[0] = 3'd0;
        func_v[1] = 3'd0;
        tt_v[0]   = 4'd0;
        tt_v[1]   = 4'd0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk("reset_outputs", 32'({a_v[g], b_v[g], busy_v[g], done_v[g], pass_v[g], err_v[g], fail_v[g]}), 0);
        rst = 1'b0;

        // NOR gate with NOR expected, then mismatched expectations
        start_run(0, 3, 4'b0001, 1); drain(0);
        repeat (3) @(negedge clk);
        chk("pass_held", 32'(pass_v[0]), 1);
        start_run(0, 0, 4'b0001, 1); drain(0);
        start_run(0, 3, 4'b0000, 1); drain(0);
        start_run(0, 5, 4'b1110, 1); drain(0);
        start_run(1, 3, 4'b0001, 1); drain(1);
        start_run(1, 6, 4'b0000, 1); drain(1);

        for (int i = 0; i < 16; i++) begin
            int g;
            g = int'($urandom_range(0, 1));
            start_run(g, int'($urandom_range(0, 7)), 4'($urandom), 1);
            drain(g);
        end

        // Second start and func changes mid-run must not disturb the run
        start_run(0, 3, 4'b0001, 1);
        repeat (3) @(negedge clk);
        start_v[0] = 1'b1;
        func_v[0]  = 3'd0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        func_v[0]  = 3'd5;
        drain(0);
        repeat (12) @(negedge clk);
        chk("no_second_run", 32'(busy_v[0]), 0);

        // Reset during vector 2 of a SETTLE=3 run
        start_run(1, 3, 4'b0000, 0);
        repeat (7) @(negedge clk);
        chk("mid_run_vector", 32'({a_v[1], b_v[1]}), 2);
        chk("mid_run_err", 32'(err_v[1]), 1);
        rst = 1'b1;
        #1;
        chk("reset_mid_run", 32'({a_v[1], b_v[1], busy_v[1], done_v[1], pass_v[1], err_v[1], fail_v[1]}), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run(1, 3, 4'b0001, 1); drain(1);
        repeat (15) @(negedge clk);
        chk("no_stray_done", 32'(exp_q[1].size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
